// File: rtl/spi_reg_ctrl_if.sv
// Byte-level SPI slave and register-file side of the command sequencer.
// master = sequencer, slave = SPI slave plus register file.
interface spi_reg_ctrl_if #(
    parameter int ADDR_W = 7
);
    logic              frame_active;
    logic [7:0]        rx_data;
    logic              rx_valid;
    logic [7:0]        tx_data;
    logic              tx_valid;
    logic              tx_done;
    logic              reg_wr_en;
    logic [ADDR_W-1:0] reg_wr_addr;
    logic [7:0]        reg_wr_data;
    logic              reg_rd_en;
    logic [ADDR_W-1:0] reg_rd_addr;
    logic [7:0]        reg_rd_data;
    logic              busy;
    logic              err_overrun;

    modport master (
        input  frame_active, rx_data, rx_valid, tx_done, reg_rd_data,
        output tx_data, tx_valid, reg_wr_en, reg_wr_addr, reg_wr_data,
        output reg_rd_en, reg_rd_addr, busy, err_overrun
    );

    modport slave (
        output frame_active, rx_data, rx_valid, tx_done, reg_rd_data,
        input  tx_data, tx_valid, reg_wr_en, reg_wr_addr, reg_wr_data,
        input  reg_rd_en, reg_rd_addr, busy, err_overrun
    );
endinterface

// File: rtl/spi_reg_ctrl.sv
// SPI command sequencer: decodes a command byte, then streams
// auto-incrementing register writes or prefetched register reads.
module spi_reg_ctrl #(
    parameter int         ADDR_W      = 7,
    parameter int         AUTO_INC    = 1,
    parameter logic [7:0] STATUS_BYTE = 8'hA5
) (
    input  logic          clk,
    input  logic          rst_n,
    spi_reg_ctrl_if.master bus
);
    typedef enum logic [2:0] {
        IDLE, CMD, WR_DATA, RD_FETCH, RD_WAIT, RD_DATA
    } state_t;

    localparam logic [ADDR_W-1:0] INC =
        (AUTO_INC != 0) ? ADDR_W'(1) : '0;

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [7:0]        tx_data_q, tx_data_d;
    logic              tx_valid_q, tx_valid_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
    logic              rd_en_q, rd_en_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              err_q, err_d;
    logic              busy_q, busy_d;
    logic              frame_q, frame_d;

    logic              rise;
    logic [ADDR_W-1:0] cmd_addr;
    logic [ADDR_W-1:0] next_addr;

    assign rise      = bus.frame_active & ~frame_q;
    assign cmd_addr  = bus.rx_data[ADDR_W-1:0];
    assign next_addr = addr_q + INC;

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        tx_data_d  = tx_data_q;
        tx_valid_d = tx_valid_q;
        wr_en_d    = 1'b0;
        wr_addr_d  = wr_addr_q;
        wr_data_d  = wr_data_q;
        rd_en_d    = 1'b0;
        rd_addr_d  = rd_addr_q;
        err_d      = err_q;
        frame_d    = bus.frame_active;

        // Frame end wins over any byte strobe in the same cycle.
        if (state_q != IDLE && !bus.frame_active) begin
            state_d    = IDLE;
            tx_valid_d = 1'b0;
        end else begin
            unique case (state_q)
                IDLE: begin
                    tx_data_d  = STATUS_BYTE;
                    tx_valid_d = ~bus.tx_done;
                    if (rise) begin
                        state_d = CMD;
                        err_d   = 1'b0;
                    end
                end
                CMD: begin
                    if (bus.tx_done) tx_valid_d = 1'b0;
                    if (bus.rx_valid) begin
                        addr_d     = cmd_addr;
                        tx_data_d  = 8'h00;
                        tx_valid_d = 1'b0;
                        if (bus.rx_data[7]) begin
                            state_d   = RD_FETCH;
                            rd_en_d   = 1'b1;
                            rd_addr_d = cmd_addr;
                        end else begin
                            state_d = WR_DATA;
                        end
                    end
                end
                WR_DATA: begin
                    tx_data_d  = 8'h00;
                    tx_valid_d = ~bus.tx_done;
                    if (bus.rx_valid) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = addr_q;
                        wr_data_d = bus.rx_data;
                        addr_d    = next_addr;
                    end
                end
                RD_FETCH: begin
                    state_d = RD_WAIT;
                    if (bus.tx_done || bus.rx_valid) err_d = 1'b1;
                end
                RD_WAIT: begin
                    state_d    = RD_DATA;
                    tx_data_d  = bus.reg_rd_data;
                    tx_valid_d = 1'b1;
                    if (bus.tx_done || bus.rx_valid) err_d = 1'b1;
                end
                RD_DATA: begin
                    if (bus.tx_done) begin
                        state_d    = RD_FETCH;
                        tx_valid_d = 1'b0;
                        tx_data_d  = 8'h00;
                        addr_d     = next_addr;
                        rd_en_d    = 1'b1;
                        rd_addr_d  = next_addr;
                    end
                end
                default: state_d = IDLE;
            endcase
        end

        busy_d = (state_d != IDLE);
    end

    // frame_q resets high so a select stuck high out of reset is no edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            tx_data_q  <= STATUS_BYTE;
            tx_valid_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= 8'h00;
            rd_en_q    <= 1'b0;
            rd_addr_q  <= '0;
            err_q      <= 1'b0;
            busy_q     <= 1'b0;
            frame_q    <= 1'b1;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            tx_data_q  <= tx_data_d;
            tx_valid_q <= tx_valid_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            rd_en_q    <= rd_en_d;
            rd_addr_q  <= rd_addr_d;
            err_q      <= err_d;
            busy_q     <= busy_d;
            frame_q    <= frame_d;
        end
    end

    assign bus.tx_data     = tx_data_q;
    assign bus.tx_valid    = tx_valid_q;
    assign bus.reg_wr_en   = wr_en_q;
    assign bus.reg_wr_addr = wr_addr_q;
    assign bus.reg_wr_data = wr_data_q;
    assign bus.reg_rd_en   = rd_en_q;
    assign bus.reg_rd_addr = rd_addr_q;
    assign bus.busy        = busy_q;
    assign bus.err_overrun = err_q;
endmodule

// File: doc/spi_reg_ctrl.md
Name: spi_reg_ctrl

Overview:
Command sequencer between the SPI byte-level slave and an internal register file. It decodes a command byte and performs auto-incrementing register writes or reads. It sequences the slave's TX load/done handshake and reports overrun errors. It sits in the clk domain; the SPI slave's byte strobes and frame flag arrive already synchronised to clk.

Parameters:
ADDR_W, 7, register address width (1..7); the command byte carries address in bits [ADDR_W-1:0], upper address bits are ignored
AUTO_INC, 1, 1 = address increments after each data byte; 0 = address fixed for the whole frame
STATUS_BYTE, 8'hA5, byte returned in the command slot of every frame

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
frame_active  in  1  high while the SPI slave select is asserted (synchronous to clk)
rx_data  in  8  received byte from the SPI slave
rx_valid  in  1  one-cycle strobe, rx_data valid
tx_data  out  8  byte handed to the SPI slave for the next slot
tx_valid  out  1  tx_data valid; held until tx_done
tx_done  in  1  one-cycle strobe, slave has latched tx_data
reg_wr_en  out  1  one-cycle register write strobe
reg_wr_addr  out  ADDR_W  write address
reg_wr_data  out  8  write data
reg_rd_en  out  1  one-cycle register read strobe
reg_rd_addr  out  ADDR_W  read address
reg_rd_data  in  8  read data, valid exactly 1 cycle after reg_rd_en
busy  out  1  high whenever state != IDLE
err_overrun  out  1  sticky overrun flag; cleared by reset or by a new frame start

Behaviour:
- Reset (async, rst_n=0): state=IDLE. All outputs are 0 except tx_data=STATUS_BYTE. One cycle after release, tx_valid=1.
- Command byte: bit7 = 1 read / 0 write; bits[ADDR_W-1:0] = start address.
- States: IDLE, CMD, WR_DATA, RD_FETCH, RD_WAIT, RD_DATA.
- IDLE: tx_data=STATUS_BYTE, tx_valid=1. Rising edge of frame_active -> CMD and clear err_overrun.
- CMD: on rx_valid, latch addr. A write command goes to WR_DATA. A read command goes to RD_FETCH.
- WR_DATA: each rx_valid -> reg_wr_en=1 the next cycle with reg_wr_addr=addr and reg_wr_data=rx_data. Then addr += AUTO_INC. tx_data=8'h00 with tx_valid=1 for every write-phase slot.
- RD_FETCH: assert reg_rd_en for 1 cycle with reg_rd_addr=addr. Go to RD_WAIT.
- RD_WAIT: capture reg_rd_data into tx_data and set tx_valid=1. Go to RD_DATA.
- RD_DATA: on tx_done, drop tx_valid, addr += AUTO_INC, go to RD_FETCH (prefetch next). rx bytes in this phase are ignored.
- Read latency: rx_valid of the command byte to tx_valid with first read data = 3 cycles. Data is ready long before the slave's next byte boundary.
- Overrun: tx_done or rx_valid arriving in RD_FETCH/RD_WAIT (data not yet loaded) sets err_overrun. tx_data=8'h00 for that slot, and the read sequence continues.
- Address wrap: addr increments modulo 2^ADDR_W (max -> 0), with no error.
- tx handshake: tx_data must be stable while tx_valid=1. After tx_done, tx_valid stays 0 for at least 1 cycle before the next load.
- Frame end (frame_active falls) in any state -> IDLE the next cycle.
  - A pending write strobe for a byte whose rx_valid preceded the fall still issues.
  - rx_valid coincident with the fall is discarded (frame end wins).
  - No partial read fetch is issued.
- frame_active high in IDLE without a rising edge (stuck high after reset) does not start a frame.
- reg_wr_en and reg_rd_en are never high in the same cycle.

Test Plan:
- Write burst: frame, bytes 0x05,0x11,0x22,0x33 -> reg_wr_en at addrs 5,6,7 with data 0x11,0x22,0x33; MISO slots = A5,00,00,00; busy low after frame end.
- Read burst: regs[0x10..0x12]=0xDE,0xAD,0xBE; frame, bytes 0x90,xx,xx,xx -> tx slots A5,DE,AD,BE; reg_rd_en once per slot plus one prefetch; no write strobes.
- Wrap: ADDR_W=7, write cmd 0x7F, data 0x01,0x02 -> writes at addr 0x7F then 0x00.
- AUTO_INC=0: read cmd 0x83 for 3 data slots -> reg_rd_addr=3 on every fetch; tx slots carry regs[3] thrice.
- Overrun: force tx_done 1 cycle after the command-byte rx_valid -> err_overrun=1, that slot 0x00. The next frame start clears err_overrun.
- Abort/reset: drop frame_active after write cmd with no data -> no reg_wr_en, IDLE, tx_data=A5. Separately, assert rst_n=0 mid-read -> all outputs reset immediately, with no clk edge required.
